bitmap_to_bmp: RTL and testbench
================================

BITMAP_TO_BMP -- requirements
Module: bitmap_to_bmp

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256, data width of both streams in bits.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128, tuser width of both streams.
REQ-003 SHALL have parameters MAX_IMAGE_WIDTH, default 50, and MAX_IMAGE_HEIGHT, default 50, the largest accepted dimensions in pixels.
REQ-004 SHALL derive local parameter TKEEP_WIDTH = TDATA_WIDTH/8.
REQ-005 SHALL have port axis_aclk, input, 1, the single clock.
REQ-006 SHALL have port axis_reset, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports bitmap_height and bitmap_width, input, 16 each, image dimensions, valid with the first pixel beat.
REQ-008 SHALL have ports bitmap_axis_tdata [TDATA_WIDTH], tkeep [TKEEP_WIDTH], tuser [TUSER_WIDTH], tvalid, tlast as inputs and tready as output; one pixel per beat, R in bits 7:0, G in 15:8, B in 23:16; tkeep and tuser ignored.
REQ-009 SHALL have ports bmp_axis_tdata, tkeep, tuser, tvalid, tlast as outputs and tready as input, carrying the BMP file byte stream; byte 0 is in tdata[7:0].
REQ-010 SHALL have port frame_error, output, 1, a one-cycle pulse.

Function
REQ-011 SHALL produce: a 54-byte header, then H rows top-down, each row W pixels as bytes B,G,R followed by pad zero bytes; pad = (4 - (3W mod 4)) mod 4; stride = 3W + pad.
REQ-012 SHALL emit header bytes, with multi-byte fields little-endian: 0-1 0x42,0x4D; 2-5 54+H*stride; 6-9 0; 10-13 54; 14-17 40; 18-21 W; 22-25 -H (two's complement); 26-27 1; 28-29 24; 30-33 0; 34-37 H*stride; 38-41 2835; 42-45 2835; 46-53 0.
REQ-013 SHALL compute all header arithmetic in 32 bits with no truncation.
REQ-014 SHALL implement states IDLE, HEADER, PIXELS, PAD, FLUSH, DROP.
REQ-015 SHALL hold bitmap_axis_tready=0 in IDLE; on bitmap_axis_tvalid, latch W and H and go to HEADER, or to DROP if W=0, H=0, W>MAX_IMAGE_WIDTH, or H>MAX_IMAGE_HEIGHT.
REQ-016 SHALL append 3 header bytes per step in HEADER (18 steps), then go to PIXELS.
REQ-017 SHALL assert bitmap_axis_tready in PIXELS only when the packer can accept 3 bytes; each accepted beat appends B,G,R and advances x, then y.
REQ-018 SHALL go to PAD after the last pixel of a row when pad≠0, appending all pad bytes in one step; SHALL go to FLUSH after the final row's pixels and pad.
REQ-019 SHALL pack bytes into full TKEEP_WIDTH-byte output beats with all tkeep bits set; leftover bytes carry into the next beat.
REQ-020 SHALL mark the beat holding the final file byte with tlast=1, and tkeep SHALL have its low (bytes in beat) bits set; FLUSH returns to IDLE once that beat is accepted.
REQ-021 SHALL drive bmp_axis_tuser=0 always.
REQ-022 SHALL hold bmp_axis_tdata/tkeep/tlast stable while tvalid=1 and tready=0; packer steps stall and bitmap_axis_tready=0 while no space is available.
REQ-023 SHALL frame by pixel count only; input tlast on a non-final pixel, or absent on the final pixel, SHALL pulse frame_error the cycle after acceptance.
REQ-024 SHALL in DROP assert bitmap_axis_tready=1, emit no output, and return to IDLE after accepting a tlast beat.
REQ-025 SHALL sustain one pixel per cycle in PIXELS when bmp_axis_tready=1.

Reset
REQ-026 SHALL, with axis_reset=1 at a clock edge, enter IDLE, clear counters and packer, and drive bmp_axis_tvalid=0, bitmap_axis_tready=0, and frame_error=0 from the next cycle.
REQ-027 SHALL discard any partial frame on reset mid-operation and emit no tail beat.

Verification (TDATA_WIDTH=256)
REQ-028 SHALL cover 2x2 image -> 70 bytes, 3 beats; bytes 2-5 = 46 00 00 00, 22-25 = FE FF FF FF; pad 2 per row; last tkeep 0x3F with tlast.
REQ-029 SHALL cover 4x1 image -> stride 12, no pad, 66 bytes; last beat tkeep 0x3.
REQ-030 SHALL cover 3x3 with bmp_axis_tready toggling every cycle -> byte stream identical to the no-stall run, 90 bytes, last tkeep 0x03FFFFFF, no input beat lost.
REQ-031 SHALL cover width=0 with a 3-beat input frame -> all beats accepted, no output, back to IDLE.
REQ-032 SHALL cover reset during a 2x2 frame's PIXELS, then a 1x1 frame -> only the 58-byte file appears; last tkeep 0x03FFFFFF.
REQ-033 SHALL cover a 2x2 frame with tlast on pixel 2 -> frame_error pulses once and the output is still a 70-byte file.

Source files
------------

// File: rtl/bitmap_to_bmp_if.sv
// AXI4-Stream bundle shared by the pixel input and the BMP byte output.
//   master: drives tdata/tkeep/tuser/tvalid/tlast, samples tready
//   slave : samples tdata/tkeep/tuser/tvalid/tlast, drives tready
interface bitmap_to_bmp_if #(
  parameter int unsigned TDATA_WIDTH = 256,
  parameter int unsigned TUSER_WIDTH = 128
);
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/bitmap_to_bmp.sv
// Converts a stream of RGB pixels (one per beat) into a 24-bit top-down BMP
// file byte stream, packed into full-width output beats.
//   axis_aclk, axis_reset         : clock, synchronous active-high reset
//   bitmap_width, bitmap_height   : image size, valid with the first pixel beat
//   bitmap_axis (slave)           : pixel stream, R[7:0] G[15:8] B[23:16]
//   bmp_axis (master)             : BMP bytes, byte 0 in tdata[7:0]
//   frame_error                   : one-cycle pulse on misplaced/missing tlast
// Assumes TDATA_WIDTH is a multiple of 32; a BMP file length is always 2 mod 4,
// so the final beat is always a partial tail emitted from FLUSH.
module bitmap_to_bmp #(
  parameter int unsigned TDATA_WIDTH      = 256,
  parameter int unsigned TUSER_WIDTH      = 128,
  parameter int unsigned MAX_IMAGE_WIDTH  = 50,
  parameter int unsigned MAX_IMAGE_HEIGHT = 50
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  input  logic [15:0]             bitmap_height,
  input  logic [15:0]             bitmap_width,
  bitmap_to_bmp_if.slave          bitmap_axis,
  bitmap_to_bmp_if.master         bmp_axis,
  output logic                    frame_error
);
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int unsigned ACC_W       = TDATA_WIDTH + 24;
  localparam int unsigned CNT_W       = $clog2(TKEEP_WIDTH + 4);

  typedef enum logic [2:0] {IDLE, HEADER, PIXELS, PAD, FLUSH, DROP} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [4:0]             hidx_q, hidx_d;
  logic [TDATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TKEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic                   tail_q, tail_d, err_q, err_d;

  logic [31:0]            three_w_c, stride_c, img_c, file_c;
  logic [1:0]             pad_c;
  logic [54*8-1:0]        hdr_c;
  logic                   out_free_c, space_c, last_col_c, last_row_c;
  logic                   step_c, in_ready_c;
  logic [1:0]             step_n_c;
  logic [23:0]            step_bytes_c;
  logic [ACC_W-1:0]       comb_c;
  logic [31:0]            sum_c;
  logic                   unused_inputs;

  assign unused_inputs = ^{bitmap_axis.tkeep, bitmap_axis.tuser,
                           bitmap_axis.tdata[TDATA_WIDTH-1:24]};

  // Row geometry and header image, all in 32-bit arithmetic
  always_comb begin
    three_w_c = 32'(w_q) * 32'd3;
    pad_c     = 2'(32'd4 - 32'(three_w_c[1:0]));
    stride_c  = three_w_c + 32'(pad_c);
    img_c     = 32'(h_q) * stride_c;
    file_c    = 32'd54 + img_c;
    hdr_c             = '0;
    hdr_c[0*8  +: 16] = 16'h4D42;
    hdr_c[2*8  +: 32] = file_c;
    hdr_c[10*8 +: 32] = 32'd54;
    hdr_c[14*8 +: 32] = 32'd40;
    hdr_c[18*8 +: 32] = 32'(w_q);
    hdr_c[22*8 +: 32] = 32'd0 - 32'(h_q);
    hdr_c[26*8 +: 16] = 16'd1;
    hdr_c[28*8 +: 16] = 16'd24;
    hdr_c[34*8 +: 32] = img_c;
    hdr_c[38*8 +: 32] = 32'd2835;
    hdr_c[42*8 +: 32] = 32'd2835;
  end

  // Next-state, packer and output register logic
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    x_d          = x_q;
    y_d          = y_q;
    hidx_d       = hidx_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    tail_d       = tail_q;
    err_d        = 1'b0;
    in_ready_c   = 1'b0;
    step_c       = 1'b0;
    step_n_c     = 2'd0;
    step_bytes_c = 24'h0;
    comb_c       = '0;
    sum_c        = 32'd0;

    out_free_c = !out_valid_q || bmp_axis.tready;
    // Room for 3 more bytes: either they stay in the accumulator or a full
    // beat can move into the (free) output register.
    space_c    = out_free_c || (32'(cnt_q) + 32'd3 < TKEEP_WIDTH);
    last_col_c = (x_q == w_q - 16'd1);
    last_row_c = (y_q == h_q - 16'd1);

    if (out_free_c) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bitmap_axis.tvalid) begin
          w_d    = bitmap_width;
          h_d    = bitmap_height;
          x_d    = 16'd0;
          y_d    = 16'd0;
          hidx_d = 5'd0;
          if (bitmap_width == 16'd0 || bitmap_height == 16'd0 ||
              32'(bitmap_width) > MAX_IMAGE_WIDTH ||
              32'(bitmap_height) > MAX_IMAGE_HEIGHT) state_d = DROP;
          else state_d = HEADER;
        end
      end
      HEADER: begin
        if (space_c) begin
          step_c       = 1'b1;
          step_n_c     = 2'd3;
          step_bytes_c = hdr_c[32'(hidx_q) * 24 +: 24];
          if (hidx_q == 5'd17) begin
            hidx_d  = 5'd0;
            state_d = PIXELS;
          end else begin
            hidx_d = hidx_q + 5'd1;
          end
        end
      end
      PIXELS: begin
        in_ready_c = space_c;
        if (bitmap_axis.tvalid && space_c) begin
          step_c       = 1'b1;
          step_n_c     = 2'd3;
          step_bytes_c = {bitmap_axis.tdata[7:0], bitmap_axis.tdata[15:8],
                          bitmap_axis.tdata[23:16]};
          err_d        = bitmap_axis.tlast != (last_col_c && last_row_c);
          if (last_col_c) begin
            x_d = 16'd0;
            if (pad_c != 2'd0) state_d = PAD;
            else if (last_row_c) state_d = FLUSH;
            else y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      PAD: begin
        if (space_c) begin
          step_c   = 1'b1;
          step_n_c = pad_c;
          if (last_row_c) state_d = FLUSH;
          else begin
            y_d     = y_q + 16'd1;
            state_d = PIXELS;
          end
        end
      end
      FLUSH: begin
        // First push the partial tail beat, then wait for it to be taken
        if (!tail_q) begin
          if (out_free_c) begin
            out_data_d  = acc_q;
            out_keep_d  = ~({TKEEP_WIDTH{1'b1}} << cnt_q);
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            tail_d      = 1'b1;
          end
        end else if (out_free_c) begin
          tail_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DROP: begin
        in_ready_c = 1'b1;
        if (bitmap_axis.tvalid && bitmap_axis.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Append step bytes above the held ones; spill a full beat when reached
    if (step_c) begin
      comb_c = ACC_W'(acc_q) | (ACC_W'(step_bytes_c) << {cnt_q, 3'b000});
      sum_c  = 32'(cnt_q) + 32'(step_n_c);
      if (sum_c >= TKEEP_WIDTH) begin
        out_data_d  = comb_c[TDATA_WIDTH-1:0];
        out_keep_d  = '1;
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        acc_d       = TDATA_WIDTH'(comb_c >> TDATA_WIDTH);
        cnt_d       = CNT_W'(sum_c - TKEEP_WIDTH);
      end else begin
        acc_d = comb_c[TDATA_WIDTH-1:0];
        cnt_d = CNT_W'(sum_c);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hidx_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tail_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hidx_q      <= hidx_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
    end
  end

  assign bitmap_axis.tready = in_ready_c;
  assign bmp_axis.tdata     = out_data_q;
  assign bmp_axis.tkeep     = out_keep_q;
  assign bmp_axis.tlast     = out_last_q;
  assign bmp_axis.tvalid    = out_valid_q;
  assign bmp_axis.tuser     = TUSER_WIDTH'(0);
  assign frame_error        = err_q;
endmodule

// File: tb/tb_bitmap_to_bmp.sv
// Directed bench for bitmap_to_bmp: builds each expected BMP file from the
// image size and pixel values and compares the captured output byte stream.
module tb_bitmap_to_bmp;
  localparam int unsigned TDW = 256;
  localparam int unsigned TUW = 128;
  localparam int unsigned KW  = TDW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] bm_w, bm_h;
  logic ferr;
  logic tog_mode   = 1'b0;
  logic ready_hold = 1'b1;

  always #5 clk = ~clk;

  bitmap_to_bmp_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) in_if ();
  bitmap_to_bmp_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) out_if ();

  bitmap_to_bmp #(
    .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW),
    .MAX_IMAGE_WIDTH(50), .MAX_IMAGE_HEIGHT(50)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .bitmap_height (bm_h),
    .bitmap_width  (bm_w),
    .bitmap_axis   (in_if),
    .bmp_axis      (out_if),
    .frame_error   (ferr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] out_bytes[$];
  logic [7:0] exp_q[$];
  int beats, files, err_pulses, stab_err, in_acc;
  logic [KW-1:0] last_keep;
  logic [7:0] px_r[16], px_g[16], px_b[16];
  logic tl[16];

  // Output back-pressure: steady level or toggling every cycle
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      if (tog_mode) out_if.tready = ~out_if.tready;
      else out_if.tready = ready_hold;
    end
  end

  // Output monitor: byte capture, hold-while-stalled check, error pulses
  logic prev_stall = 1'b0;
  logic [TDW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic prev_last;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall && (out_if.tvalid !== 1'b1 || out_if.tdata !== prev_data ||
            out_if.tkeep !== prev_keep || out_if.tlast !== prev_last)) stab_err++;
        if (out_if.tvalid && out_if.tready) begin
          for (int k = 0; k < KW; k++)
            if (out_if.tkeep[k]) out_bytes.push_back(out_if.tdata[8*k +: 8]);
          beats++;
          if (out_if.tlast) begin
            files++;
            last_keep = out_if.tkeep;
          end
        end
        if (ferr === 1'b1) err_pulses++;
        prev_stall = out_if.tvalid && !out_if.tready;
        prev_data  = out_if.tdata;
        prev_keep  = out_if.tkeep;
        prev_last  = out_if.tlast;
      end
    end
  end

  task automatic clear_obs();
    out_bytes.delete();
    beats = 0; err_pulses = 0; stab_err = 0; in_acc = 0; last_keep = '0;
  endtask

  task automatic load_pixels(input int n);
    for (int i = 0; i < 16; i++) begin
      px_r[i] = 8'(8'h10 + i);
      px_g[i] = 8'(8'h40 + 3 * i);
      px_b[i] = 8'(8'h80 + 5 * i);
      tl[i]   = (i == n - 1);
    end
  endtask

  task automatic push_le(input int unsigned v, input int nb);
    for (int b = 0; b < nb; b++) exp_q.push_back(8'(v >> (8 * b)));
  endtask

  task automatic build_exp(input int w, input int h);
    int pad, stride, img;
    pad    = (4 - ((3 * w) % 4)) % 4;
    stride = 3 * w + pad;
    img    = h * stride;
    exp_q.delete();
    exp_q.push_back(8'h42); exp_q.push_back(8'h4D);
    push_le(54 + img, 4); push_le(0, 4); push_le(54, 4); push_le(40, 4);
    push_le(w, 4); push_le(32'(-h), 4); push_le(1, 2); push_le(24, 2);
    push_le(0, 4); push_le(img, 4); push_le(2835, 4); push_le(2835, 4);
    push_le(0, 4); push_le(0, 4);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        exp_q.push_back(px_b[y*w+x]);
        exp_q.push_back(px_g[y*w+x]);
        exp_q.push_back(px_r[y*w+x]);
      end
      for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
    end
  endtask

  function automatic int count_mism();
    int m = 0;
    if (out_bytes.size() != exp_q.size()) m++;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= out_bytes.size() || out_bytes[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic send_pixels(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_if.tvalid = 1'b1;
      in_if.tdata  = {8{$urandom()}};
      in_if.tdata[23:0] = {px_b[i], px_g[i], px_r[i]};
      in_if.tlast  = tl[i];
      in_if.tkeep  = $urandom();
      in_if.tuser  = {4{$urandom()}};
      g = 0;
      #4;
      while (in_if.tready !== 1'b1 && g < 2000) begin
        @(negedge clk);
        #4;
        g++;
      end
      if (in_if.tready === 1'b1) in_acc++;
      else begin
        checks++; errors++;
        $display("FAIL send_timeout: pixel %0d not accepted, tready=%b want 1", i, in_if.tready);
        break;
      end
    end
    @(negedge clk);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic wait_file(input int start);
    int g = 0;
    while (files == start && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (files == start) begin
      checks++; errors++;
      $display("FAIL wait_tlast: files=%0d want %0d", files, start + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", out_if.tvalid); end
    checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", in_if.tready); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", ferr); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_2x2();
    int f0;
    clear_obs(); bm_w = 16'd2; bm_h = 16'd2; load_pixels(4); build_exp(2, 2);
    f0 = files;
    send_pixels(4);
    wait_file(f0);
    checks++; if (out_bytes.size() != 70) begin errors++; $display("FAIL 2x2_size: got %0d want 70", out_bytes.size()); end
    checks++; if (beats != 3) begin errors++; $display("FAIL 2x2_beats: got %0d want 3", beats); end
    checks++; if ({out_bytes[5], out_bytes[4], out_bytes[3], out_bytes[2]} !== 32'h0000_0046) begin
      errors++; $display("FAIL 2x2_filesize: got %h want 00000046", {out_bytes[5], out_bytes[4], out_bytes[3], out_bytes[2]}); end
    checks++; if ({out_bytes[25], out_bytes[24], out_bytes[23], out_bytes[22]} !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL 2x2_neg_h: got %h want fffffffe", {out_bytes[25], out_bytes[24], out_bytes[23], out_bytes[22]}); end
    checks++; if (last_keep !== 32'h0000_003F) begin errors++; $display("FAIL 2x2_keep: got %h want 0000003f", last_keep); end
    checks++; if (files != f0 + 1) begin errors++; $display("FAIL 2x2_tlast: got %0d files want %0d", files - f0, 1); end
    checks++; if (count_mism() != 0) begin errors++; $display("FAIL 2x2_bytes: %0d mismatches want 0", count_mism()); end
  endtask

  task automatic test_4x1();
    int f0;
    clear_obs(); bm_w = 16'd4; bm_h = 16'd1; load_pixels(4); build_exp(4, 1);
    f0 = files;
    send_pixels(4);
    wait_file(f0);
    checks++; if (out_bytes.size() != 66) begin errors++; $display("FAIL 4x1_size: got %0d want 66", out_bytes.size()); end
    checks++; if (last_keep !== 32'h0000_0003) begin errors++; $display("FAIL 4x1_keep: got %h want 00000003", last_keep); end
    checks++; if (count_mism() != 0) begin errors++; $display("FAIL 4x1_bytes: %0d mismatches want 0", count_mism()); end
  endtask

  task automatic test_stall_3x3();
    int f0;
    clear_obs(); bm_w = 16'd3; bm_h = 16'd3; load_pixels(9); build_exp(3, 3);
    f0 = files;
    tog_mode = 1'b1;
    send_pixels(9);
    wait_file(f0);
    tog_mode = 1'b0;
    checks++; if (out_bytes.size() != 90) begin errors++; $display("FAIL 3x3_size: got %0d want 90", out_bytes.size()); end
    checks++; if (last_keep !== 32'h03FF_FFFF) begin errors++; $display("FAIL 3x3_keep: got %h want 03ffffff", last_keep); end
    checks++; if (count_mism() != 0) begin errors++; $display("FAIL 3x3_bytes: %0d mismatches want 0", count_mism()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL 3x3_hold: %0d unstable stalled beats want 0", stab_err); end
    checks++; if (in_acc != 9) begin errors++; $display("FAIL 3x3_in_beats: got %0d want 9", in_acc); end
  endtask

  task automatic test_drop();
    clear_obs(); bm_w = 16'd0; bm_h = 16'd2; load_pixels(3);
    send_pixels(3);
    repeat (10) @(negedge clk);
    #4;
    checks++; if (in_acc != 3) begin errors++; $display("FAIL drop_accepted: got %0d want 3", in_acc); end
    checks++; if (beats != 0) begin errors++; $display("FAIL drop_output: got %0d beats want 0", beats); end
    checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL drop_idle_tready: got %b want 0", in_if.tready); end
  endtask

  task automatic test_reset_mid();
    int f0;
    clear_obs(); ready_hold = 1'b0; bm_w = 16'd2; bm_h = 16'd2; load_pixels(4);
    send_pixels(1);
    repeat (2) @(negedge clk);
    checks++; if (beats != 0) begin errors++; $display("FAIL rstmid_early: got %0d beats want 0", beats); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_hold = 1'b1;
    repeat (2) @(negedge clk);
    bm_w = 16'd1; bm_h = 16'd1; load_pixels(1); build_exp(1, 1);
    f0 = files;
    send_pixels(1);
    wait_file(f0);
    checks++; if (out_bytes.size() != 58) begin errors++; $display("FAIL rstmid_size: got %0d want 58", out_bytes.size()); end
    checks++; if (last_keep !== 32'h03FF_FFFF) begin errors++; $display("FAIL rstmid_keep: got %h want 03ffffff", last_keep); end
    checks++; if (count_mism() != 0) begin errors++; $display("FAIL rstmid_bytes: %0d mismatches want 0", count_mism()); end
  endtask

  task automatic test_frame_error();
    int f0;
    clear_obs(); bm_w = 16'd2; bm_h = 16'd2; load_pixels(4); build_exp(2, 2);
    tl[1] = 1'b1;
    f0 = files;
    send_pixels(4);
    wait_file(f0);
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", err_pulses); end
    checks++; if (out_bytes.size() != 70) begin errors++; $display("FAIL ferr_size: got %0d want 70", out_bytes.size()); end
    checks++; if (count_mism() != 0) begin errors++; $display("FAIL ferr_bytes: %0d mismatches want 0", count_mism()); end
  endtask

  initial begin
    rst = 1'b1;
    bm_w = '0; bm_h = '0;
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0;
    in_if.tdata = '0; in_if.tkeep = '0; in_if.tuser = '0;
    beats = 0; files = 0; err_pulses = 0; stab_err = 0; in_acc = 0; last_keep = '0;
    test_reset();
    test_2x2();
    test_4x1();
    test_stall_3x3();
    test_drop();
    test_reset_mid();
    test_frame_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
